// File: rtl/popcount24_tnn_seq_ctrl.sv
// popcount24_tnn_seq_ctrl
// Ternary-neuron sequencer that time-shares one external popcount24 core.
// For each 24-bit chunk the positive-weight mask count is added to a signed
// accumulator, then the negative-weight mask count is subtracted. After
// NUM_CHUNKS chunks the signed sum and activation (sum >= threshold) are held
// on the output until the consumer takes them.
// Optional build macro: POPCNT_SKIP_ZERO_EN -- skip POS/NEG phases whose mask
// is all zeros, so sparse chunks finish in fewer cycles.
`timescale 1ns/1ps

module popcount24_tnn_seq_ctrl #(
    parameter int NUM_CHUNKS = 4,
    parameter int ACC_W      = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [23:0]             in_pos,
    input  logic [23:0]             in_neg,
    input  logic signed [ACC_W-1:0] in_thresh,
    output logic [23:0]             pc_operand,
    input  logic [4:0]              pc_count,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_sum,
    output logic                    out_act,
    output logic                    busy
);

    // Chunk counter needs at least one bit even for a single-chunk neuron
    localparam int CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_POS  = 2'd1;
    localparam logic [1:0] S_NEG  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]              r_state;
    logic [CNT_W-1:0]        r_chunkCnt;
    logic [23:0]             r_pos;
    logic [23:0]             r_neg;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] r_thr;
    logic signed [ACC_W-1:0] r_sum;
    logic                    r_act;

    // The core count is used raw (0..31); approximate cores may exceed 24
    logic signed [ACC_W-1:0] w_pcExt;
    logic signed [ACC_W-1:0] w_accPlus;
    logic signed [ACC_W-1:0] w_accMinus;
    logic                    w_lastChunk;
    logic                    w_accept;

    assign w_pcExt     = $signed({{(ACC_W-5){1'b0}}, pc_count});
    assign w_accPlus   = r_acc + w_pcExt;
    assign w_accMinus  = r_acc - w_pcExt;
    assign w_lastChunk = (r_chunkCnt == LAST_CHUNK);
    assign w_accept    = in_valid && (r_state == S_IDLE);

`ifdef POPCNT_SKIP_ZERO_EN
    // When a whole chunk is skipped in IDLE the accumulator base and threshold
    // must reflect a first chunk that is being accepted this very cycle
    logic signed [ACC_W-1:0] w_accBase;
    logic signed [ACC_W-1:0] w_thrNow;

    assign w_accBase = (r_chunkCnt == '0) ? '0 : r_acc;
    assign w_thrNow  = (r_chunkCnt == '0) ? in_thresh : r_thr;
`endif

    // Handshake and status outputs decode directly from the state register
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign out_sum   = r_sum;
    assign out_act   = r_act;

    // Steer the latched mask of the active phase to the shared core, quiet otherwise
    always_comb begin
        pc_operand = 24'd0;
        case (r_state)
            S_POS:   pc_operand = r_pos;
            S_NEG:   pc_operand = r_neg;
            default: pc_operand = 24'd0;
        endcase
    end

    // Main sequencer: chunk intake, accumulate/subtract phases, result hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_chunkCnt <= '0;
            r_pos      <= 24'd0;
            r_neg      <= 24'd0;
            r_acc      <= '0;
            r_thr      <= '0;
            r_sum      <= '0;
            r_act      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_pos <= in_pos;
                        r_neg <= in_neg;
                        if (r_chunkCnt == '0) begin
                            r_acc <= '0;
                            r_thr <= in_thresh;
                        end
`ifdef POPCNT_SKIP_ZERO_EN
                        if (in_pos != 24'd0) begin
                            r_state <= S_POS;
                        end else if (in_neg != 24'd0) begin
                            r_state <= S_NEG;
                        end else if (w_lastChunk) begin
                            r_state    <= S_DONE;
                            r_chunkCnt <= '0;
                            r_sum      <= w_accBase;
                            r_act      <= (w_accBase >= w_thrNow);
                        end else begin
                            r_chunkCnt <= r_chunkCnt + CNT_W'(1);
                        end
`else
                        r_state <= S_POS;
`endif
                    end
                end

                S_POS: begin
                    r_acc <= w_accPlus;
`ifdef POPCNT_SKIP_ZERO_EN
                    if (r_neg != 24'd0) begin
                        r_state <= S_NEG;
                    end else if (w_lastChunk) begin
                        r_state    <= S_DONE;
                        r_chunkCnt <= '0;
                        r_sum      <= w_accPlus;
                        r_act      <= (w_accPlus >= r_thr);
                    end else begin
                        r_state    <= S_IDLE;
                        r_chunkCnt <= r_chunkCnt + CNT_W'(1);
                    end
`else
                    r_state <= S_NEG;
`endif
                end

                S_NEG: begin
                    r_acc <= w_accMinus;
                    if (w_lastChunk) begin
                        r_state    <= S_DONE;
                        r_chunkCnt <= '0;
                        r_sum      <= w_accMinus;
                        r_act      <= (w_accMinus >= r_thr);
                    end else begin
                        r_state    <= S_IDLE;
                        r_chunkCnt <= r_chunkCnt + CNT_W'(1);
                    end
                end

                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
